fm_cycle_sched: RTL and testbench

FM_CYCLE_SCHED -- requirements
Module: fm_cycle_sched

---
 rtl/fm_pkg.sv | 15 +
 rtl/fm_cyc_timer.sv | 41 ++++
 rtl/fm_cycle_sched.sv | 87 ++++++++
 tb/tb_fm_cycle_sched.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// Frame-memory cycle scheduler shared definitions.
// Cycle geometry, starvation limit and slot-type encoding.
package fm_pkg;

  localparam int CYC_LEN    = 72;
  localparam int STARVE_MAX = 3;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_IV_WR = 2'd1,
    SLOT_OV_RD = 2'd2,
    SLOT_IV_RD = 2'd3
  } slot_e;

endpackage

// File: rtl/fm_cyc_timer.sv
// Free-running frame-memory cycle counter.
// Produces the registered advance pulse and the arbitration strobe.
module fm_cyc_timer
  import fm_pkg::*;
#(
  parameter int CYC_LEN = fm_pkg::CYC_LEN
) (
  input  logic clk,
  input  logic rst,
  output logic stp_adv,
  output logic arb
);

  localparam logic [6:0] QC_LAST = 7'(CYC_LEN - 1);
  localparam logic [6:0] QC_STP  = 7'(CYC_LEN - 3);
  localparam logic [6:0] QC_ARB  = 7'(CYC_LEN - 4);

  logic [6:0] qc_q, qc_d;
  logic       stp_adv_q, stp_adv_d;

  // Next count; pulse is precomputed so it is high while qc sits at STP.
  always_comb begin
    qc_d      = (qc_q == QC_LAST) ? 7'd0 : qc_q + 7'd1;
    stp_adv_d = (qc_d == QC_STP);
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qc_q      <= 7'd0;
      stp_adv_q <= 1'b0;
    end else begin
      qc_q      <= qc_d;
      stp_adv_q <= stp_adv_d;
    end
  end

  assign stp_adv = stp_adv_q;
  assign arb     = (qc_q == QC_ARB);

endmodule

// File: rtl/fm_cycle_sched.sv
// Frame-memory slot scheduler: one grant per cycle,
// fixed priority with anti-starvation for iv_rd.
module fm_cycle_sched
  import fm_pkg::*;
#(
  parameter int CYC_LEN    = fm_pkg::CYC_LEN,
  parameter int STARVE_MAX = fm_pkg::STARVE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sched_en,
  input  logic        iv_wr_req,
  input  logic        ov_rd_req,
  input  logic        iv_rd_req,
  output logic        fm_cycle_stp_adv,
  output logic        fm_iv_wr_cycle,
  output logic        fm_ov_rd_cycle,
  output logic        fm_iv_rd_cycle,
  output logic [15:0] fm_slot_cnt
);

  localparam logic [2:0] SC_MAX = 3'(STARVE_MAX);

  logic        arb;
  slot_e       slot_q, slot_d;
  logic [2:0]  sc_q, sc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        any_req;

  fm_cyc_timer #(
    .CYC_LEN (CYC_LEN)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .stp_adv (fm_cycle_stp_adv),
    .arb     (arb)
  );

  assign any_req = iv_wr_req | ov_rd_req | iv_rd_req;

  // Arbitrate once per cycle; otherwise hold grant and counters.
  always_comb begin
    slot_d = slot_q;
    sc_d   = sc_q;
    cnt_d  = cnt_q;
    if (arb) begin
      slot_d = SLOT_IDLE;
      if (sched_en && any_req) begin
        if (iv_rd_req && (sc_q == SC_MAX))
          slot_d = SLOT_IV_RD;
        else if (iv_wr_req)
          slot_d = SLOT_IV_WR;
        else if (ov_rd_req)
          slot_d = SLOT_OV_RD;
        else
          slot_d = SLOT_IV_RD;
        if (slot_d == SLOT_IV_RD) begin
          sc_d  = 3'd0;
          cnt_d = cnt_q + 16'd1;
        end else if (iv_rd_req) begin
          sc_d  = sc_q + 3'd1;
        end else begin
          sc_d  = 3'd0;
        end
      end
    end
  end

  // Grant, starvation and status registers; reset drops grants at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= SLOT_IDLE;
      sc_q   <= 3'd0;
      cnt_q  <= 16'd0;
    end else begin
      slot_q <= slot_d;
      sc_q   <= sc_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fm_iv_wr_cycle = (slot_q == SLOT_IV_WR);
  assign fm_ov_rd_cycle = (slot_q == SLOT_OV_RD);
  assign fm_iv_rd_cycle = (slot_q == SLOT_IV_RD);
  assign fm_slot_cnt    = cnt_q;

endmodule

// File: tb/tb_fm_cycle_sched.sv
// Directed bench for fm_cycle_sched.
// Tracks cycle position by counting clock edges since reset release.
module tb_fm_cycle_sched;

  localparam int CL = 72;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sched_en = 1'b0;
  logic        iv_wr_req = 1'b0;
  logic        ov_rd_req = 1'b0;
  logic        iv_rd_req = 1'b0;
  logic        stp;
  logic        g_wr, g_ov, g_rd;
  logic [15:0] cnt;

  int n = 0;
  int vecs = 0;
  int miss = 0;

  fm_cycle_sched dut (
    .clk              (clk),
    .rst              (rst),
    .sched_en         (sched_en),
    .iv_wr_req        (iv_wr_req),
    .ov_rd_req        (ov_rd_req),
    .iv_rd_req        (iv_rd_req),
    .fm_cycle_stp_adv (stp),
    .fm_iv_wr_cycle   (g_wr),
    .fm_ov_rd_cycle   (g_ov),
    .fm_iv_rd_cycle   (g_rd),
    .fm_slot_cnt      (cnt)
  );

  always #4 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s n=%0d obs=%0h exp=%0h",
             tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic wait_qc(input int q);
    do step(); while ((n % CL) != q);
  endtask

  task automatic next_slot();
    wait_qc(70);
  endtask

  function automatic logic [2:0] gv();
    return {g_wr, g_ov, g_rd};
  endfunction

  initial begin
    logic [2:0] exp_g;
    logic [15:0] exp_cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_stp", stp, 1'b0);
    chk("rst_grant", gv(), 3'b000);
    chk("rst_cnt", cnt, 16'd0);
    rst = 1'b0;
    n = 0;

    for (int i = 1; i <= 220; i++) begin
      step();
      chk("idle_stp", stp, ((n % CL) == 69));
      chk("idle_grant", gv(), 3'b000);
    end

    sched_en  = 1'b1;
    iv_wr_req = 1'b1;
    ov_rd_req = 1'b1;
    iv_rd_req = 1'b1;
    exp_cnt = 16'd0;
    for (int i = 0; i < 8; i++) begin
      next_slot();
      exp_g = ((i % 4) == 3) ? 3'b001 : 3'b100;
      if ((i % 4) == 3) exp_cnt++;
      chk("all_grant", gv(), exp_g);
      chk("all_cnt", cnt, exp_cnt);
    end

    iv_wr_req = 1'b0;
    wait_qc(30);
    chk("drop_hold", gv(), 3'b001);
    for (int i = 0; i < 8; i++) begin
      next_slot();
      exp_g = ((i % 4) == 3) ? 3'b001 : 3'b010;
      if ((i % 4) == 3) exp_cnt++;
      chk("ovrd_grant", gv(), exp_g);
      chk("ovrd_cnt", cnt, exp_cnt);
    end

    ov_rd_req = 1'b0;
    iv_rd_req = 1'b0;
    next_slot();
    chk("none_grant", gv(), 3'b000);
    wait_qc(10);
    iv_rd_req = 1'b1;
    wait_qc(15);
    chk("pulse_cur", gv(), 3'b000);
    wait_qc(21);
    iv_rd_req = 1'b0;
    next_slot();
    chk("pulse_next", gv(), 3'b000);
    chk("pulse_cnt", cnt, exp_cnt);

    iv_wr_req = 1'b1;
    next_slot();
    chk("en_wr", gv(), 3'b100);
    wait_qc(30);
    sched_en = 1'b0;
    wait_qc(40);
    chk("en_hold40", gv(), 3'b100);
    wait_qc(68);
    chk("en_hold68", gv(), 3'b100);
    next_slot();
    chk("en_idle", gv(), 3'b000);
    sched_en = 1'b1;
    next_slot();
    chk("en_back", gv(), 3'b100);

    wait_qc(40);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", gv(), 3'b000);
    chk("arst_stp", stp, 1'b0);
    chk("arst_cnt", cnt, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    for (int i = 1; i <= 70; i++) begin
      step();
      chk("rel_stp", stp, (n == 69));
      chk("rel_grant", gv(), (n >= 69) ? 3'b100 : 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
